// File: rtl/adc_snap_ctrl_if.sv
// adc_snap_ctrl_if -- sample stream in, snapshot BRAM write port out.
// The controller takes the master view (drives the BRAM write port, consumes
// the qualified ADC stream); the sample source / BRAM side takes the slave view.
`timescale 1ns/1ps
interface adc_snap_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              trig_in;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;

  modport master (
    input  trig_in, valid_in, data_in,
    output bram_we, bram_addr, bram_data
  );

  modport slave (
    output trig_in, valid_in, data_in,
    input  bram_we, bram_addr, bram_data
  );
endinterface

// File: rtl/adc_snap_ctrl.sv
// adc_snap_ctrl -- ADC snapshot capture controller.
// Arms on a rising edge of ctrl_in[0], waits for a trigger (immediate or
// external), then streams qualified samples into a BRAM with a one-cycle
// registered write port, and reports progress through a registered status word.
// Optional build macro SNAP_CIRC_EN: pre-trigger circular capture. While armed
// every valid sample is written at a wrapping address; the trigger sample's
// address is latched into trig_addr and half a buffer of post-trigger samples
// (trigger sample included) is captured before DONE.
`timescale 1ns/1ps
module adc_snap_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic                  user_clk,
  input  logic                  user_rst_n,
  input  logic [31:0]           ctrl_in,
  adc_snap_ctrl_if.master       bus,
  output logic [31:0]           status_out
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  // Count needs one extra bit so a full buffer reads 2^ADDR_W instead of 0.
  localparam int CNT_W = ADDR_W + 1;
`ifdef SNAP_CIRC_EN
  localparam int CAP_WORDS = 1 << (ADDR_W - 1);
`else
  localparam int CAP_WORDS = 1 << ADDR_W;
`endif
  localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(CAP_WORDS - 1);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_arm_d, r_primed;
  logic              w_arm_edge, w_trig, w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_bram_we;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [DATA_W-1:0] r_bram_data;
  logic [31:0]       r_status, w_status;
  logic              w_ctrl_unused;
`ifdef SNAP_CIRC_EN
  logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_nxt, w_trig_addr_nxt;
`endif

  // Only arm and trig_sel are defined in the control word.
  assign w_ctrl_unused = ^ctrl_in[31:2];

  // r_primed keeps the first clock after reset from seeing a fake 0->1 arm edge.
  assign w_arm_edge = r_primed & ctrl_in[0] & ~r_arm_d;
  assign w_trig     = bus.valid_in & (ctrl_in[1] | bus.trig_in);

  // Next-state, next-count and write-request decode; arm edge overrides all.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_we        = 1'b0;
`ifdef SNAP_CIRC_EN
    w_wr_ptr_nxt    = r_wr_ptr;
    w_trig_addr_nxt = r_trig_addr;
    w_addr          = r_wr_ptr;
`else
    w_addr          = r_count[ADDR_W-1:0];
`endif
    if (w_arm_edge) begin
      w_state_nxt = S_ARMED;
      w_count_nxt = '0;
`ifdef SNAP_CIRC_EN
      w_wr_ptr_nxt    = '0;
      w_trig_addr_nxt = '0;
`endif
    end else begin
      case (r_state)
        S_ARMED: begin
`ifdef SNAP_CIRC_EN
          if (bus.valid_in) begin
            w_we         = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
            if (w_trig) begin
              w_trig_addr_nxt = r_wr_ptr;
              w_count_nxt     = CNT_W'(1);
              w_state_nxt     = S_CAPTURE;
            end
          end
`else
          if (w_trig) begin
            w_we        = 1'b1;
            w_count_nxt = CNT_W'(1);
            w_state_nxt = S_CAPTURE;
          end
`endif
        end
        S_CAPTURE: begin
          if (bus.valid_in) begin
            w_we        = 1'b1;
            w_count_nxt = r_count + CNT_W'(1);
`ifdef SNAP_CIRC_EN
            w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
`endif
            if (r_count == CAP_LAST) w_state_nxt = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Status word built from the current state, count and trigger address.
  always_comb begin
    w_status        = '0;
    w_status[31]    = (r_state == S_DONE);
    w_status[30]    = (r_state == S_ARMED);
    w_status[29]    = (r_state == S_CAPTURE);
    w_status[27:16] = 12'(r_trig_addr);
    w_status[12:0]  = 13'(r_count);
  end

  // State, counters, arm-edge history and the registered BRAM write port.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_arm_d     <= 1'b0;
      r_primed    <= 1'b0;
      r_bram_we   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_data <= '0;
      r_status    <= '0;
`ifdef SNAP_CIRC_EN
      r_wr_ptr    <= '0;
      r_trig_addr <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_arm_d   <= ctrl_in[0];
      r_primed  <= 1'b1;
      r_bram_we <= w_we;
      r_status  <= w_status;
      if (w_we) begin
        r_bram_addr <= w_addr;
        r_bram_data <= bus.data_in;
      end
`ifdef SNAP_CIRC_EN
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_trig_addr <= w_trig_addr_nxt;
`endif
    end
  end

`ifndef SNAP_CIRC_EN
  // Without circular capture the trigger address is always zero.
  assign r_trig_addr = '0;
`endif

  assign bus.bram_we   = r_bram_we;
  assign bus.bram_addr = r_bram_addr;
  assign bus.bram_data = r_bram_data;
  assign status_out    = r_status;

endmodule

// File: doc/adc_snap_ctrl.md
ADC_SNAP_CTRL -- requirements
Module: adc_snap_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning snapshot BRAM address width (legal 4..12; depth 2^ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning sample/BRAM data width.
REQ-003 SHALL have port user_clk  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port user_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ctrl_in  input  32  control word from the PPC-to-Simulink register: bit0 arm, bit1 trig_sel (1 = immediate, 0 = external).
REQ-006 SHALL have port trig_in  input  1  external trigger, sampled only when valid_in=1.
REQ-007 SHALL have port valid_in  input  1  data_in qualifier.
REQ-008 SHALL have port data_in  input  DATA_W  ADC sample word.
REQ-009 SHALL have port bram_we  output  1  BRAM write enable.
REQ-010 SHALL have port bram_addr  output  ADDR_W  BRAM write address.
REQ-011 SHALL have port bram_data  output  DATA_W  BRAM write data.
REQ-012 SHALL have port status_out  output  32  status word for the Simulink-to-PPC status register: bit31 done, bit30 armed, bit29 capturing, bits[27:16] trig_addr (zero-extended), bits[12:0] word count.

Function
REQ-013 SHALL detect arm as a 0->1 edge of ctrl_in[0] registered in user_clk; a level held high SHALL NOT re-arm.
REQ-014 SHALL implement FSM states IDLE, ARMED, CAPTURE, DONE.
REQ-015 IDLE/DONE: arm edge -> ARMED next cycle, count cleared to 0, done cleared to 0, trig_addr cleared to 0.
REQ-016 ARMED: when valid_in=1 and (trig_sel=1 or trig_in=1) -> CAPTURE; that trigger sample SHALL be written at count 0 in the same cycle.
REQ-017 CAPTURE: each valid_in=1 cycle writes data_in at bram_addr=count and increments count; cycles with valid_in=0 SHALL NOT write or advance.
REQ-018 Write timing: bram_we, bram_addr, bram_data SHALL be registered, asserted one cycle after the qualifying valid_in cycle (fixed latency 1).
REQ-019 When the write of address 2^ADDR_W-1 is issued, FSM -> DONE; count SHALL read 2^ADDR_W (no wrap to 0); no further writes.
REQ-020 Arm edge in ARMED or CAPTURE SHALL abort and restart: -> ARMED, count=0, no write issued for that cycle's sample.
REQ-021 Arm edge coincident with a trigger or final write: arm wins; final write suppressed, state ARMED.
REQ-022 status_out SHALL be registered, updated every cycle from current state, count and trig_addr; unused bits read 0.

Reset
REQ-023 On user_rst_n=0 (asynchronous), state=IDLE, count=0, trig_addr=0, arm edge register=0, bram_we=0, bram_addr=0, bram_data=0, status_out=0.
REQ-024 Release of reset SHALL NOT generate an arm edge even if ctrl_in[0]=1 at release (edge register loads ctrl_in[0] on first clock).

Configuration
REQ-025 Macro SNAP_CIRC_EN SHALL select pre-trigger circular capture.
REQ-026 With SNAP_CIRC_EN defined: in ARMED every valid sample SHALL be written at a wrapping address (modulo 2^ADDR_W); on trigger the trigger sample's address SHALL be latched into trig_addr; CAPTURE SHALL then write exactly 2^(ADDR_W-1) samples including the trigger sample, then -> DONE; count reports post-trigger samples written.
REQ-027 Without SNAP_CIRC_EN: no writes in ARMED; trig_addr SHALL read 0 always; behaviour per REQ-016..REQ-019.

Verification
REQ-028 Reset with ctrl_in=1, release -> status_out=0, no bram_we for 20 cycles.
REQ-029 ADDR_W=4, ctrl_in 0->1 with bit1=1, valid_in=1 continuous, data_in=incrementing from 0x100 -> 16 writes addr 0..15 data 0x100..0x10F, then status_out=0x8000_0010.
REQ-030 trig_sel=0, trig_in pulsed with valid_in=0 -> no capture; pulsed with valid_in=1 -> capture starts, first write one cycle later at addr 0.
REQ-031 valid_in toggling 1/0 during CAPTURE -> writes only on valid cycles, addresses contiguous, 16 writes total.
REQ-032 Arm edge after 7 writes -> state ARMED, count=0, status bit30=1, next trigger rewrites from addr 0.
REQ-033 SNAP_CIRC_EN, ADDR_W=4, 21 valid samples in ARMED then trigger -> trig_addr=5, 8 further writes addrs 5..12, done=1, count=8.
